// File: rtl/dlx_pkg.sv
// Shared DLX definitions: opcodes, the ID/EX pipeline register layout,
// and the instruction-format classifier used by decode.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LHI   = 6'h0F;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        is_load;
    logic        is_store;
    logic        reg_write;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_LOAD, FMT_STORE, FMT_BR, FMT_J, FMT_JAL, FMT_JALR
  } fmt_e;

  // Anything not listed decodes as an I-type ALU op.
  function automatic fmt_e op_format(input logic [5:0] op);
    case (op)
      OP_RTYPE:                           return FMT_R;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return FMT_LOAD;
      OP_SB, OP_SH, OP_SW:                return FMT_STORE;
      OP_BEQZ, OP_BNEZ, OP_JR:            return FMT_BR;
      OP_J:                               return FMT_J;
      OP_JAL:                             return FMT_JAL;
      OP_JALR:                            return FMT_JALR;
      default:                            return FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID-side bundle of the decode stage: the offered instruction, the
// flush, the stall back-pressure and the register-file read port.
interface id_stage_if;
  // ifid_* is a transfer offer while ifid_valid = 1; stall acts as not-ready:
  // while stall = 1 the offer is not consumed and ifid_* must stay constant.
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        flush;
  logic        stall;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] s1;
  logic [31:0] s2;

  modport master (
    output ifid_valid, ifid_instr, ifid_pc, flush, s1, s2,
    input  stall, rs1, rs2
  );

  modport slave (
    input  ifid_valid, ifid_instr, ifid_pc, flush, s1, s2,
    output stall, rs1, rs2
  );
endinterface

// File: rtl/id_imm_gen.sv
// Immediate extender: zero-extends logical immediates, shifts LHI,
// sign-extends the 26-bit jump offset, sign-extends 16 bits otherwise.
module id_imm_gen
  import dlx_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [25:0] field,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{16{field[15]}}, field[15:0]};
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, field[15:0]};
      OP_LHI:                   imm = {field[15:0], 16'h0000};
      OP_J, OP_JAL:             imm = {{6{field[25]}}, field};
      default:                  imm = {{16{field[15]}}, field[15:0]};
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// DLX decode stage: register-number split, operand/immediate latch into
// ID/EX, one-bubble load-use interlock and taken-branch squash.
module id_stage
  import dlx_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  id_stage_if.slave              id,
  output logic                   ex_valid,
  output logic [31:0]            ex_pc,
  output logic [5:0]             ex_op,
  output logic [5:0]             ex_func,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic [4:0]             ex_rd,
  output logic [31:0]            ex_a,
  output logic [31:0]            ex_b,
  output logic [31:0]            ex_imm,
  output logic                   ex_is_load,
  output logic                   ex_is_store,
  output logic                   ex_reg_write,
  output logic [STALL_CNT_W-1:0] stall_count
);

  idex_t                  idex;
  idex_t                  dec;
  logic [STALL_CNT_W-1:0] cnt;
  logic [5:0]             op;
  logic [31:0]            imm;
  logic [4:0]             dec_rs1, dec_rs2, dec_rd;
  logic                   dec_load, dec_store, dec_rw;
  logic                   hz;

  assign op = id.ifid_instr[31:26];

  id_imm_gen u_imm (
    .op    (op),
    .field (id.ifid_instr[25:0]),
    .imm   (imm)
  );

  // Unused sources stay 0 so they can never match a load destination.
  always_comb begin
    dec_rs1   = id.ifid_instr[25:21];
    dec_rs2   = 5'd0;
    dec_rd    = 5'd0;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_rw    = 1'b0;
    case (op_format(op))
      FMT_R: begin
        dec_rs2 = id.ifid_instr[20:16];
        dec_rd  = id.ifid_instr[15:11];
        dec_rw  = 1'b1;
      end
      FMT_I: begin
        dec_rd = id.ifid_instr[20:16];
        dec_rw = 1'b1;
      end
      FMT_LOAD: begin
        dec_rd   = id.ifid_instr[20:16];
        dec_rw   = 1'b1;
        dec_load = 1'b1;
      end
      FMT_STORE: begin
        dec_rs2   = id.ifid_instr[20:16];
        dec_store = 1'b1;
      end
      FMT_J:   dec_rs1 = 5'd0;
      FMT_JAL: begin
        dec_rs1 = 5'd0;
        dec_rd  = 5'd31;
        dec_rw  = 1'b1;
      end
      FMT_JALR: begin
        dec_rd = 5'd31;
        dec_rw = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dec           = BUBBLE;
    dec.valid     = id.ifid_valid;
    dec.pc        = id.ifid_pc;
    dec.op        = op;
    dec.func      = id.ifid_instr[5:0];
    dec.rs1       = dec_rs1;
    dec.rs2       = dec_rs2;
    dec.rd        = dec_rd;
    dec.a         = id.s1;
    dec.b         = id.s2;
    dec.imm       = imm;
    dec.is_load   = dec_load & id.ifid_valid;
    dec.is_store  = dec_store & id.ifid_valid;
    dec.reg_write = dec_rw & id.ifid_valid;
  end

  assign hz = id.ifid_valid & idex.valid & idex.is_load & (idex.rd != 5'd0) &
              ((idex.rd == dec_rs1) | (idex.rd == dec_rs2));

  assign id.rs1   = dec_rs1;
  assign id.rs2   = dec_rs2;
  assign id.stall = hz & ~id.flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idex <= BUBBLE;
      cnt  <= '0;
    end else if (id.flush) begin
      idex <= BUBBLE;
    end else if (hz) begin
      idex <= BUBBLE;
      if (cnt != {STALL_CNT_W{1'b1}})
        cnt <= cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      idex <= dec;
    end
  end

  assign ex_valid     = idex.valid;
  assign ex_pc        = idex.pc;
  assign ex_op        = idex.op;
  assign ex_func      = idex.func;
  assign ex_rs1       = idex.rs1;
  assign ex_rs2       = idex.rs2;
  assign ex_rd        = idex.rd;
  assign ex_a         = idex.a;
  assign ex_b         = idex.b;
  assign ex_imm       = idex.imm;
  assign ex_is_load   = idex.is_load;
  assign ex_is_store  = idex.is_store;
  assign ex_reg_write = idex.reg_write;
  assign stall_count  = cnt;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a driver pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_id_stage;
  import dlx_pkg::*;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  id_stage_if ifc ();

  logic          ex_valid, ex_is_load, ex_is_store, ex_reg_write;
  logic [31:0]   ex_pc, ex_a, ex_b, ex_imm;
  logic [5:0]    ex_op, ex_func;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] stall_count;

  id_stage #(.STALL_CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id           (ifc),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_op        (ex_op),
    .ex_func      (ex_func),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_imm       (ex_imm),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_reg_write (ex_reg_write),
    .stall_count  (stall_count)
  );

  typedef struct {
    bit            chk_rs;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    bit            chk_st;
    logic          stall;
    logic [CW-1:0] cnt;
    bit            chk_ex;
    idex_t         ex;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  idex_t ex_exp;

  function automatic idex_t mk(input logic [31:0] pc, input logic [5:0] op, func,
                               input logic [4:0] r1, r2, rd,
                               input logic [31:0] a, b, imm,
                               input logic ld, st, rw);
    idex_t e;
    e = '{valid: 1'b1, pc: pc, op: op, func: func, rs1: r1, rs2: r2, rd: rd,
          a: a, b: b, imm: imm, is_load: ld, is_store: st, reg_write: rw};
    return e;
  endfunction

  task automatic cmp(input string name, input logic [159:0] act, exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, queue what the DUT must show
  // before the next edge (ex_exp is the ID/EX content left by the prior cycle).
  task automatic cyc(input logic rst, v, input logic [31:0] instr, pc,
                     input logic fl, input logic [31:0] a, b,
                     input bit crs, input logic [4:0] r1, r2,
                     input bit cst, input logic st, input logic [CW-1:0] cnt,
                     input bit cex);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n          = rst;
    ifc.ifid_valid   = v;
    ifc.ifid_instr   = instr;
    ifc.ifid_pc      = pc;
    ifc.flush        = fl;
    ifc.s1           = a;
    ifc.s2           = b;
    e.chk_rs = crs; e.rs1 = r1; e.rs2 = r2;
    e.chk_st = cst; e.stall = st; e.cnt = cnt;
    e.chk_ex = cex; e.ex = ex_exp;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t  e;
    idex_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = '{valid: ex_valid, pc: ex_pc, op: ex_op, func: ex_func,
                rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, a: ex_a, b: ex_b,
                imm: ex_imm, is_load: ex_is_load, is_store: ex_is_store,
                reg_write: ex_reg_write};
        if (e.chk_rs) begin
          cmp("rs1", 160'(ifc.rs1), 160'(e.rs1));
          cmp("rs2", 160'(ifc.rs2), 160'(e.rs2));
        end
        if (e.chk_st) begin
          cmp("stall", 160'(ifc.stall), 160'(e.stall));
          cmp("stall_count", 160'(stall_count), 160'(e.cnt));
        end
        if (e.chk_ex) cmp("idex", 160'(act), 160'(e.ex));
      end
    end
  end

  initial begin : driver
    logic [31:0]   pc;
    logic [CW-1:0] n;
    reset_n = 1'b0;
    ifc.ifid_valid = 1'b0; ifc.ifid_instr = '0; ifc.ifid_pc = '0;
    ifc.flush = 1'b0; ifc.s1 = '0; ifc.s2 = '0;
    ex_exp = BUBBLE;

    // reset with junk inputs
    cyc(0, 1, 32'hDEADBEEF, 32'h0, 1, 32'hFFFF, 32'hAAAA, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEADBEEF, 32'h4, 0, 32'h1234, 32'h5678, 0, 0, 0, 1, 0, 0, 1);
    // ADD r3,r1,r2
    cyc(1, 1, 32'h00221820, 32'h100, 0, 5, 7, 1, 1, 2, 1, 0, 0, 1);
    ex_exp = mk(32'h100, 6'h00, 6'h20, 1, 2, 3, 5, 7, 32'h1820, 0, 0, 1);
    // LW r5,4(r1) then ADD r6,r5,r2: one bubble
    cyc(1, 1, 32'h8C250004, 32'h104, 0, 32'h1000, 32'h99, 1, 1, 0, 1, 0, 0, 1);
    ex_exp = mk(32'h104, 6'h23, 6'h04, 1, 0, 5, 32'h1000, 32'h99, 32'h4, 1, 0, 1);
    cyc(1, 1, 32'h00A23020, 32'h108, 0, 32'h11, 32'h22, 1, 5, 2, 1, 1, 0, 1);
    ex_exp = BUBBLE;
    cyc(1, 1, 32'h00A23020, 32'h108, 0, 32'h33, 32'h22, 1, 5, 2, 1, 0, 1, 1);
    ex_exp = mk(32'h108, 6'h00, 6'h20, 5, 2, 6, 32'h33, 32'h22, 32'h3020, 0, 0, 1);
    // immediates: ADDI, ORI, JAL
    cyc(1, 1, 32'h2004FFFF, 32'h10C, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h10C, 6'h08, 6'h3F, 0, 0, 4, 0, 0, 32'hFFFFFFFF, 0, 0, 1);
    cyc(1, 1, 32'h3404FFFF, 32'h110, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h110, 6'h0D, 6'h3F, 0, 0, 4, 0, 0, 32'h0000FFFF, 0, 0, 1);
    cyc(1, 1, 32'h0C000010, 32'h114, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h114, 6'h03, 6'h10, 0, 0, 31, 0, 0, 32'h10, 0, 0, 1);
    // LW r7 then dependent ADD with flush: flush wins
    cyc(1, 1, 32'h8C470000, 32'h118, 0, 32'h200, 0, 1, 2, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h118, 6'h23, 6'h00, 2, 0, 7, 32'h200, 0, 0, 1, 0, 1);
    cyc(1, 1, 32'h00E14020, 32'h11C, 1, 1, 2, 1, 7, 1, 1, 0, 1, 1);
    ex_exp = BUBBLE;
    // LW r0 then use of r0: no stall
    cyc(1, 1, 32'h8C200000, 32'h200, 0, 32'h40, 0, 1, 1, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h200, 6'h23, 6'h00, 1, 0, 0, 32'h40, 0, 0, 1, 0, 1);
    cyc(1, 1, 32'h00004820, 32'h204, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h204, 6'h00, 6'h20, 0, 0, 9, 0, 0, 32'h4820, 0, 0, 1);
    // SW r3,8(r1), LHI r2,0x1234, then an empty slot
    cyc(1, 1, 32'hAC230008, 32'h208, 0, 32'h10, 32'h55, 1, 1, 3, 1, 0, 1, 1);
    ex_exp = mk(32'h208, 6'h2B, 6'h08, 1, 3, 0, 32'h10, 32'h55, 32'h8, 0, 1, 0);
    cyc(1, 1, 32'h3C021234, 32'h20C, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);
    ex_exp = mk(32'h20C, 6'h0F, 6'h34, 0, 0, 2, 0, 0, 32'h12340000, 0, 0, 1);
    cyc(1, 0, 32'h0, 32'h210, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1);

    // drive the counter to saturation and one hazard past it
    for (int i = 0; i < 15; i++) begin
      pc = 32'h400 + 32'(i * 16);
      n  = CW'(i + 1);
      cyc(1, 1, 32'h8C250004, pc, 0, 32'h1000, 0, 1, 1, 0, 1, 0, n, 0);
      ex_exp = mk(pc, 6'h23, 6'h04, 1, 0, 5, 32'h1000, 0, 32'h4, 1, 0, 1);
      cyc(1, 1, 32'h00A23020, pc + 4, 0, 32'h11, 32'h22, 1, 5, 2, 1, 1, n, 1);
      ex_exp = BUBBLE;
      cyc(1, 1, 32'h00A23020, pc + 4, 0, 32'h11, 32'h22, 1, 5, 2, 1, 0,
          (n == 4'd15) ? 4'd15 : n + 4'd1, 1);
    end

    // reset arriving while stalled
    cyc(1, 1, 32'h8C250004, 32'h300, 0, 32'h1000, 0, 1, 1, 0, 1, 0, 15, 0);
    ex_exp = mk(32'h300, 6'h23, 6'h04, 1, 0, 5, 32'h1000, 0, 32'h4, 1, 0, 1);
    cyc(0, 1, 32'h00A23020, 32'h304, 0, 32'h11, 32'h22, 1, 5, 2, 1, 1, 15, 1);
    ex_exp = BUBBLE;
    cyc(1, 1, 32'h00A23020, 32'h304, 0, 32'h11, 32'h22, 1, 5, 2, 1, 0, 0, 1);
    ex_exp = mk(32'h304, 6'h00, 6'h20, 5, 2, 6, 32'h11, 32'h22, 32'h3020, 0, 0, 1);
    cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1);

    repeat (3) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the DLX pipeline. Takes the IF/ID instruction word and PC, splits out the register numbers, and drives them to the register file. It latches the returned operands, immediate and control into the ID/EX pipeline register. It also detects load-use hazards, inserting one bubble while holding fetch, and squashes the decoded instruction on a taken-branch flush.

## Interface
- STALL_CNT_W, 32, width of the saturating stall-cycle counter
- clk  in  1  clock; everything updates on posedge
- reset_n  in  1  reset, synchronous and active-low
- ifid_valid  in  1  IF/ID holds a real instruction
- ifid_instr  in  32  instruction word
- ifid_pc  in  32  PC of that instruction
- flush  in  1  taken branch resolved downstream; kill the instruction currently in ID
- rs1, rs2  out  5 each  register numbers to the register file (combinational)
- s1, s2  in  32 each  operands returned by the register file in the same cycle
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  32  PC
- ex_op, ex_func  out  6 each  opcode, function field
- ex_rs1, ex_rs2, ex_rd  out  5 each  source and destination register numbers
- ex_a, ex_b  out  32 each  latched s1, s2
- ex_imm  out  32  extended immediate
- ex_is_load, ex_is_store, ex_reg_write  out  1 each  control
- stall_count  out  STALL_CNT_W  number of load-use bubbles inserted, saturating

## Operation
- Fields: op = instr[31:26], func = instr[5:0].
- R-type (op 0x00): rs1 = [25:21], rs2 = [20:16], rd = [15:11], reg_write = 1.
- I-type ALU and load: rs1 = [25:21], rs2 = 0, rd = [20:16], reg_write = 1.
- Store (SB/SH/SW): rs1 = [25:21], rs2 = [20:16], rd = 0, reg_write = 0.
- BEQZ/BNEZ, JR: rs1 = [25:21], rs2 = 0, rd = 0, reg_write = 0.
- J: rs1 = rs2 = rd = 0, reg_write = 0.
- JAL/JALR: rd = 31, reg_write = 1; JALR also uses rs1 = [25:21].
- Unused sources are driven as 0, so they never match a hazard.
- When ifid_valid = 0, rs1/rs2 are still driven from the word, but nothing is latched as valid.
- Immediate rules:
  - sign-extend [15:0] by default;
  - zero-extend for ANDI/ORI/XORI (0x0C/0x0D/0x0E);
  - LHI (0x0F) gives [15:0] << 16;
  - J/JAL sign-extend [25:0].
- Hazard condition `hz` = ifid_valid & ex_valid & ex_is_load & ex_rd != 0 & (ex_rd == rs1 | ex_rd == rs2).
- ID/EX update each cycle, in priority order:
  - reset: all ex_* = 0, stall_count = 0;
  - else if flush: bubble (ex_valid = 0, every control bit 0); stall = 0;
  - else if hz: bubble; stall = 1; stall_count += 1, saturating at all-ones;
  - else: latch the decoded fields with ex_valid = ifid_valid; stall = 0.
- A bubble clears ex_valid, ex_is_load, ex_is_store and ex_reg_write. The data fields of a bubble are don't-care; they are cleared to 0 for determinism.
- A hazard cannot persist: after one bubble ex_valid = 0, so the next cycle proceeds.

## Timing
- rs1, rs2 and stall are combinational from ifid_instr, ifid_valid and the ID/EX registers. The register-file read, including its writeback bypass, completes in the same cycle.
- Latency is 1 cycle from IF/ID to ID/EX.
- A load-use pair costs exactly 1 bubble cycle. stall is high for that single cycle, and IF/ID is unchanged the following cycle.
- flush asserted with hz: flush wins, no stall, no count increment.
- reset_n low mid-stall: the next edge clears everything and stall drops the same cycle (ex_valid = 0).
- The upstream stage must keep ifid_* constant while stall = 1.

## Structure
- Shared package `dlx_pkg`:
  - opcode localparams (OP_RTYPE 0x00, J 0x02, JAL 0x03, BEQZ 0x04, BNEZ 0x05, ADDI 0x08, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LHI 0x0F, JR 0x12, JALR 0x13, LB 0x20, LW 0x23, SB 0x28, SW 0x2B);
  - `idex_t` struct for the pipeline register;
  - a BUBBLE constant.
- One sub-module, `id_imm_gen`: a combinational immediate extender taking op and instr[25:0].

## Test plan
- Reset low for 2 cycles with junk inputs -> all ex_* = 0, stall_count = 0, stall = 0.
- ADD r3,r1,r2 (0x00221820) with s1 = 5, s2 = 7 -> rs1 = 1, rs2 = 2 same cycle; next cycle ex_rd = 3, ex_a = 5, ex_b = 7, ex_reg_write = 1.
- LW r5,4(r1) (0x8C250004) then ADD r6,r5,r2 (0x00A23020):
  - one cycle with stall = 1 and a bubble in ID/EX;
  - the ADD lands in ID/EX the following cycle;
  - stall_count = 1.
- Immediates:
  - ADDI r4,r0,-1 (0x2004FFFF) -> ex_imm = 0xFFFFFFFF;
  - ORI (0x3404FFFF) -> 0x0000FFFF;
  - JAL (0x0C000010) -> ex_imm = 0x10, ex_rd = 31.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, bubble, stall_count unchanged. A LW r0 followed by a use of r0 -> no stall.
- Force stall_count to its maximum (STALL_CNT_W = 4, 15 hazards), then one more hazard -> count stays 15.
